// File: rtl/crc16_rx_checker.sv
// crc16_rx_checker
//
// Receive-side CRC16 checker and stripper for the serial bitstream decoding
// path. It sits between bit-unstuffing and the packet field parser. Each
// packet ends in a 16-bit inverted CRC16 field, sent MSB first. This block
// forwards only the payload bits in front of that field. When a packet
// closes, it reports pass/fail against the fixed CRC16 residual.
//
// Ports:
//   clock       rising-edge clock
//   reset_n     asynchronous active-low reset
//   bit_in      serial data bit, qualified by bit_valid
//   bit_valid   bit_in is valid this cycle
//   sop         start of packet; the current valid bit is the first bit
//   eop         end of packet; the packet closes after any same-cycle bit
//   data_out    stripped payload bit (the bit received 16 bits earlier)
//   data_valid  data_out is valid this cycle (combinational from bit_valid)
//   busy        a packet is in progress
//   pkt_done    one-cycle pulse; crc_ok/crc_err/short_pkt have been updated
//   crc_ok      last closed packet passed; held until the next accepted sop
//   crc_err     last closed packet failed; held until the next accepted sop
//   short_pkt   last closed packet had fewer than 16 bits (implies crc_err)
//   abort       one-cycle pulse when a packet in progress is discarded by sop

module crc16_rx_checker #(
  parameter logic [15:0] POLY      = 16'h8005,
  parameter logic [15:0] INIT      = 16'hFFFF,
  parameter logic [15:0] RESIDUAL  = 16'h800D,
  parameter int          CNT_WIDTH = 11
) (
  input  logic clock,
  input  logic reset_n,
  input  logic bit_in,
  input  logic bit_valid,
  input  logic sop,
  input  logic eop,
  output logic data_out,
  output logic data_valid,
  output logic busy,
  output logic pkt_done,
  output logic crc_ok,
  output logic crc_err,
  output logic short_pkt,
  output logic abort
);

  typedef enum logic {IDLE, RECV} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_PAYLOAD = CNT_WIDTH'(16);

  state_t               state, state_next;
  logic [15:0]          crc, crc_next;
  logic [15:0]          delay, delay_next;
  logic [CNT_WIDTH-1:0] cnt, cnt_next;
  logic [15:0]          crc_upd;
  logic [CNT_WIDTH-1:0] cnt_upd;
  logic                 start;
  logic                 pkt_done_next, abort_next;
  logic                 crc_ok_next, crc_err_next, short_next;

  // One MSB-feedback Galois step of the CRC register.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = b ^ c[15];
    return {c[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
  endfunction

  assign start = bit_valid && sop;

  // The CRC and the count include any bit arriving in the current cycle.
  // An eop in the same cycle therefore sees the final values. The count
  // saturates, and only the ">= 16" test depends on it, so the CRC result
  // is unaffected once the count saturates.
  assign crc_upd = bit_valid ? crc_step(crc, bit_in) : crc;
  assign cnt_upd = (bit_valid && cnt != CNT_MAX) ? cnt + CNT_WIDTH'(1) : cnt;

  // The delay line holds the last 16 bits. Its oldest bit can be forwarded
  // only when at least 16 bits are already stored. That way the trailing
  // check field is never forwarded. A restarting sop bit is never payload.
  assign data_valid = bit_valid && (state == RECV) && (cnt >= CNT_PAYLOAD) && !sop;
  assign data_out   = delay[15];
  assign busy       = (state == RECV);

  // Next-state logic. A valid sop restarts the packet in either state and
  // wins over a same-cycle eop. In RECV a restart also raises abort for the
  // discarded packet. The status flags clear one cycle after the accepted
  // sop. So when a sop follows eop directly, the old packet's pkt_done and
  // flags are still visible in the sop cycle.
  always_comb begin
    state_next    = state;
    crc_next      = crc;
    cnt_next      = cnt;
    delay_next    = delay;
    pkt_done_next = 1'b0;
    abort_next    = 1'b0;
    crc_ok_next   = crc_ok;
    crc_err_next  = crc_err;
    short_next    = short_pkt;
    if (start) begin
      crc_next     = crc_step(INIT, bit_in);
      cnt_next     = CNT_WIDTH'(1);
      delay_next   = {15'b0, bit_in};
      crc_ok_next  = 1'b0;
      crc_err_next = 1'b0;
      short_next   = 1'b0;
      abort_next   = (state == RECV);
      state_next   = RECV;
    end else if (state == RECV) begin
      crc_next = crc_upd;
      cnt_next = cnt_upd;
      if (bit_valid) begin
        delay_next = {delay[14:0], bit_in};
      end
      if (eop) begin
        pkt_done_next = 1'b1;
        crc_ok_next   = (cnt_upd >= CNT_PAYLOAD) && (crc_upd == RESIDUAL);
        crc_err_next  = !((cnt_upd >= CNT_PAYLOAD) && (crc_upd == RESIDUAL));
        short_next    = (cnt_upd < CNT_PAYLOAD);
        state_next    = IDLE;
      end
    end
  end

  // State and registered status outputs. Reset drops any packet in
  // progress without a pkt_done.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      crc       <= INIT;
      cnt       <= '0;
      delay     <= '0;
      pkt_done  <= 1'b0;
      abort     <= 1'b0;
      crc_ok    <= 1'b0;
      crc_err   <= 1'b0;
      short_pkt <= 1'b0;
    end else begin
      state     <= state_next;
      crc       <= crc_next;
      cnt       <= cnt_next;
      delay     <= delay_next;
      pkt_done  <= pkt_done_next;
      abort     <= abort_next;
      crc_ok    <= crc_ok_next;
      crc_err   <= crc_err_next;
      short_pkt <= short_next;
    end
  end

endmodule
